// File: rtl/pipelined_adder_n_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : pipelined_adder_n_if                                           |
// | Brief   : Operand/result handshake bundle for pipelined_adder_n.         |
// |           master = producer of operands and consumer of results.        |
// |           slave  = the adder itself.                                     |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
interface pipelined_adder_n_if #(
   parameter int N = 32
) ();
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         cin;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] s;
   logic         cout;
   logic         ovf;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, s, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, s, cout, ovf
   );
endinterface
`default_nettype wire

// File: rtl/pipelined_adder_n.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : pipelined_adder_n                                              |
// | Brief   : N-bit add/subtract with the carry chain split into STAGES      |
// |           registered segments of W = N/STAGES bits. Valid/ready flow     |
// |           control, one result per cycle, latency STAGES cycles.          |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module pipelined_adder_n #(
   parameter int N      = 32,
   parameter int STAGES = 4
) (
   input  logic               clk,
   input  logic               rst,
   pipelined_adder_n_if.slave bus
);
   localparam int W = N / STAGES;

   // Per-stage inputs: index k is what stage k consumes. Operands are shifted
   // right one segment per stage so every stage adds the low W bits; the sum
   // is shifted right with each new segment inserted at the top, so after the
   // last stage all segments sit in their natural positions.
   logic [N-1:0] a_pipe     [STAGES];
   logic [N-1:0] b_pipe     [STAGES];
   logic [N-1:0] sum_pipe   [STAGES];
   logic         carry_pipe [STAGES];
   logic         valid_pipe [STAGES];

   logic en;

   // Whole pipeline moves when the output slot is empty or being drained.
   assign en           = ~bus.out_valid | bus.out_ready;
   assign bus.in_ready = en & ~rst;

   // Subtract folds into add as a + ~b + 1; sub/cin are consumed here so they
   // travel with their operation as the effective operand and carry.
   assign a_pipe[0]     = bus.a;
   assign b_pipe[0]     = bus.sub ? ~bus.b : bus.b;
   assign carry_pipe[0] = bus.sub | bus.cin;
   assign sum_pipe[0]   = '0;
   assign valid_pipe[0] = bus.in_valid & bus.in_ready;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [W:0]   seg_sum;
      logic [N-1:0] sum_d,   sum_q;
      logic         carry_d, carry_q;
      logic         valid_d, valid_q;

      // Add this segment and push it in at the top of the shifting sum.
      always_comb begin
         seg_sum = {1'b0, a_pipe[k][W-1:0]} + {1'b0, b_pipe[k][W-1:0]}
                 + {{W{1'b0}}, carry_pipe[k]};
         sum_d   = sum_q;
         carry_d = carry_q;
         valid_d = valid_q;
         if (en) begin
            sum_d           = sum_pipe[k] >> W;
            sum_d[N-1 -: W] = seg_sum[W-1:0];
            carry_d         = seg_sum[W];
            valid_d         = valid_pipe[k];
         end
      end

      // Stage registers; reset clears valid and zeroes the result fields.
      always_ff @(posedge clk) begin
         if (rst) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
         end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
            valid_q <= valid_d;
         end
      end

      if (k < STAGES - 1) begin : g_mid
         logic [N-1:0] a_d, a_q;
         logic [N-1:0] b_d, b_q;

         // Drop the segment just consumed so the next one lands at bit 0.
         always_comb begin
            a_d = en ? (a_pipe[k] >> W) : a_q;
            b_d = en ? (b_pipe[k] >> W) : b_q;
         end

         // Delay the not-yet-added operand bits alongside the partial sum.
         always_ff @(posedge clk) begin
            if (rst) begin
               a_q <= '0;
               b_q <= '0;
            end else begin
               a_q <= a_d;
               b_q <= b_d;
            end
         end

         assign a_pipe[k+1]     = a_q;
         assign b_pipe[k+1]     = b_q;
         assign sum_pipe[k+1]   = sum_q;
         assign carry_pipe[k+1] = carry_q;
         assign valid_pipe[k+1] = valid_q;
      end else begin : g_last
         logic ovf_d, ovf_q;
         logic c_msb;

         // Carry into the MSB is recovered from the MSB sum bit and operands.
         always_comb begin
            c_msb = seg_sum[W-1] ^ a_pipe[k][W-1] ^ b_pipe[k][W-1];
            ovf_d = en ? (c_msb ^ seg_sum[W]) : ovf_q;
         end

         // Overflow flag is registered alongside the final sum and carry.
         always_ff @(posedge clk) begin
            if (rst) begin
               ovf_q <= 1'b0;
            end else begin
               ovf_q <= ovf_d;
            end
         end

         assign bus.out_valid = valid_q;
         assign bus.s         = sum_q;
         assign bus.cout      = carry_q;
         assign bus.ovf       = ovf_q;
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder_n.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_pipelined_adder_n                                           |
// | Brief   : Directed self-checking bench: a 32-bit/4-stage instance and a  |
// |           4-bit/2-stage instance swept exhaustively.                     |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_pipelined_adder_n;
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   pipelined_adder_n_if #(.N(32)) bus32 ();
   pipelined_adder_n_if #(.N(4))  bus4  ();

   pipelined_adder_n #(.N(32), .STAGES(4)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
   pipelined_adder_n #(.N(4),  .STAGES(2)) dut4  (.clk(clk), .rst(rst), .bus(bus4));

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [33:0] q32 [$];
   logic [33:0] q4  [$];
   int          acc_cnt32 = 0;
   int          ret_cnt32 = 0;
   int          ret_cnt4  = 0;
   bit          acc32;

   // Compare one observed value against its expected value.
   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Reference: {ovf, cout, s} for an n-bit add/subtract.
   function automatic logic [33:0] golden(input int n, input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub);
      logic [63:0] m, m1, bp, full, low;
      logic        c0, co, cmsb;
      m    = (64'd1 << n) - 64'd1;
      m1   = (64'd1 << (n - 1)) - 64'd1;
      bp   = sub ? (~{32'd0, b} & m) : ({32'd0, b} & m);
      c0   = sub ? 1'b1 : cin;
      full = ({32'd0, a} & m) + bp + {63'd0, c0};
      low  = ({32'd0, a} & m1) + (bp & m1) + {63'd0, c0};
      co   = full[n];
      cmsb = low[n-1];
      return {cmsb ^ co, co, full[31:0] & m[31:0]};
   endfunction

   // One clock: score handshakes that the coming edge will perform.
   task automatic step();
      #1;
      acc32 = (bus32.in_valid === 1'b1) && (bus32.in_ready === 1'b1);
      if ((bus32.out_valid === 1'b1) && (bus32.out_ready === 1'b1)) begin
         if (q32.size() == 0) check("out32_unexpected", 64'(bus32.out_valid), 64'd0);
         else begin
            check("res32", 64'({bus32.ovf, bus32.cout, bus32.s}), 64'(q32.pop_front()));
            ret_cnt32++;
         end
      end
      if (acc32) begin
         q32.push_back(golden(32, bus32.a, bus32.b, bus32.cin, bus32.sub));
         acc_cnt32++;
      end
      if ((bus4.out_valid === 1'b1) && (bus4.out_ready === 1'b1)) begin
         if (q4.size() == 0) check("out4_unexpected", 64'(bus4.out_valid), 64'd0);
         else begin
            check("res4", 64'({bus4.ovf, bus4.cout, 28'd0, bus4.s}), 64'(q4.pop_front()));
            ret_cnt4++;
         end
      end
      if ((bus4.in_valid === 1'b1) && (bus4.in_ready === 1'b1))
         q4.push_back(golden(4, {28'd0, bus4.a}, {28'd0, bus4.b}, bus4.cin, bus4.sub));
      @(posedge clk);
      #1;
   endtask

   task automatic drive32(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
      bus32.a   = a;
      bus32.b   = b;
      bus32.cin = cin;
      bus32.sub = sub;
   endtask

   task automatic drive_rand32();
      drive32($urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          r0, a0, nv, first, last, nstale;
      bit          held;
      logic [31:0] s_hold;

      rst = 1'b1;
      bus32.in_valid = 1'b0; bus32.out_ready = 1'b1; drive32(32'd0, 32'd0, 1'b0, 1'b0);
      bus4.in_valid  = 1'b0; bus4.out_ready  = 1'b1;
      bus4.a = 4'd0; bus4.b = 4'd0; bus4.cin = 1'b0; bus4.sub = 1'b0;
      step();
      step();

      // Reset state
      check("rst_out_valid", 64'(bus32.out_valid), 64'd0);
      check("rst_s",         64'(bus32.s),         64'd0);
      check("rst_cout_ovf",  64'({bus32.cout, bus32.ovf}), 64'd0);
      check("rst_in_ready",  64'(bus32.in_ready),  64'd0);
      check("rst_out4",      64'(bus4.out_valid),  64'd0);
      rst = 1'b0;
      #1;
      check("ready_after_rst", 64'(bus32.in_ready), 64'd1);

      // Wrap-around with exact latency
      drive32(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
      bus32.in_valid = 1'b1;
      step();
      bus32.in_valid = 1'b0;
      check("lat_edge0", 64'(bus32.out_valid), 64'd0);
      step();
      check("lat_edge1", 64'(bus32.out_valid), 64'd0);
      step();
      check("lat_edge2", 64'(bus32.out_valid), 64'd0);
      step();
      check("lat_edge3", 64'(bus32.out_valid), 64'd1);
      check("wrap_result", 64'({bus32.ovf, bus32.cout, bus32.s}), 64'({1'b0, 1'b1, 32'h0000_0000}));

      // Signed overflow followed by a subtraction, back to back
      drive32(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
      bus32.in_valid = 1'b1;
      step();
      drive32(32'd5, 32'd7, 1'b0, 1'b1);
      step();
      bus32.in_valid = 1'b0;
      step();
      step();
      check("ovf_valid",  64'(bus32.out_valid), 64'd1);
      check("ovf_result", 64'({bus32.ovf, bus32.cout, bus32.s}), 64'({1'b1, 1'b0, 32'h8000_0000}));
      step();
      check("sub_valid",  64'(bus32.out_valid), 64'd1);
      check("sub_result", 64'({bus32.ovf, bus32.cout, bus32.s}), 64'({1'b0, 1'b0, 32'hFFFF_FFFE}));
      step();

      // Back-to-back stream of 8 random operations
      r0 = ret_cnt32; nv = 0; first = -1; last = -1;
      for (int i = 0; i < 20; i++) begin
         if (i < 8) begin
            drive_rand32();
            bus32.in_valid = 1'b1;
         end else begin
            bus32.in_valid = 1'b0;
         end
         step();
         if (bus32.out_valid === 1'b1) begin
            nv++;
            if (first < 0) first = i;
            last = i;
         end
      end
      check("stream_valid_cycles", 64'(nv), 64'd8);
      check("stream_contiguous",   64'(last - first + 1), 64'd8);
      check("stream_retired",      64'(ret_cnt32 - r0), 64'd8);

      // Output stall with input held valid
      bus32.out_ready = 1'b0;
      a0 = acc_cnt32; held = 1'b0; s_hold = '0;
      drive_rand32();
      bus32.in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         if (acc32) drive_rand32();
         if (bus32.out_valid === 1'b1) begin
            if (!held) begin
               s_hold = bus32.s;
               held   = 1'b1;
            end else begin
               check("stall_s_stable", 64'(bus32.s), 64'(s_hold));
            end
            check("stall_in_ready", 64'(bus32.in_ready), 64'd0);
         end
      end
      check("stall_accepted", 64'(acc_cnt32 - a0), 64'd4);
      check("stall_buffered", 64'(q32.size()), 64'd4);
      bus32.in_valid  = 1'b0;
      bus32.out_ready = 1'b1;
      r0 = ret_cnt32;
      for (int i = 0; i < 12; i++) step();
      check("stall_drained", 64'(ret_cnt32 - r0), 64'd4);
      check("stall_queue_empty", 64'(q32.size()), 64'd0);

      // Reset with three operations in flight
      for (int i = 0; i < 3; i++) begin
         drive_rand32();
         bus32.in_valid = 1'b1;
         step();
      end
      bus32.in_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("midrst_in_ready", 64'(bus32.in_ready), 64'd0);
      step();
      q32.delete();
      check("midrst_out_valid", 64'(bus32.out_valid), 64'd0);
      check("midrst_s",         64'(bus32.s),         64'd0);
      rst = 1'b0;
      nstale = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (bus32.out_valid !== 1'b0) nstale++;
      end
      check("midrst_no_stale", 64'(nstale), 64'd0);

      // Exhaustive sweep of the 4-bit, 2-stage instance
      r0 = ret_cnt4;
      for (int ia = 0; ia < 16; ia++)
         for (int ib = 0; ib < 16; ib++)
            for (int ic = 0; ic < 2; ic++)
               for (int is = 0; is < 2; is++) begin
                  bus4.a        = 4'(ia);
                  bus4.b        = 4'(ib);
                  bus4.cin      = 1'(ic);
                  bus4.sub      = 1'(is);
                  bus4.in_valid = 1'b1;
                  step();
               end
      bus4.in_valid = 1'b0;
      for (int i = 0; i < 10; i++) step();
      check("sweep4_retired", 64'(ret_cnt4 - r0), 64'd1024);
      check("sweep4_queue_empty", 64'(q4.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/pipelined_adder_n.md
PIPELINED_ADDER_N -- requirements
Module: pipelined_adder_n

Interface
REQ-001 The block SHALL have parameter N, default 32: operand/sum width in bits.
REQ-002 The block SHALL have parameter STAGES, default 4: number of carry-chain pipeline segments; N mod STAGES = 0 required; segment width W = N/STAGES.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operand set present.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block accepts operands this cycle.
REQ-007 The block SHALL have port a, input, N bits: operand A.
REQ-008 The block SHALL have port b, input, N bits: operand B.
REQ-009 The block SHALL have port cin, input, 1 bit: carry-in, used in add mode only.
REQ-010 The block SHALL have port sub, input, 1 bit: 0 = add, 1 = subtract.
REQ-011 The block SHALL have port out_valid, output, 1 bit: result present.
REQ-012 The block SHALL have port out_ready, input, 1 bit: downstream accepts result.
REQ-013 The block SHALL have port s, output, N bits: sum/difference.
REQ-014 The block SHALL have port cout, output, 1 bit: carry-out of bit N-1; in subtract mode 1 = no borrow.
REQ-015 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow.

Function
REQ-016 The block SHALL compute, for an accepted transfer, effective B' = sub ? ~b : b and carry-in c0 = sub ? 1 : cin; {cout, s} = a + B' + c0, modulo 2^(N+1).
REQ-017 The block SHALL compute ovf = carry into bit N-1 XOR cout.
REQ-018 Segment k (0..STAGES-1) SHALL add bits [k*W +: W] in pipeline stage k using the registered carry from stage k-1 (c0 for k = 0); higher-segment operands SHALL be delayed and lower-segment sums carried forward so each result emerges aligned.
REQ-019 A transfer SHALL occur on the input when in_valid & in_ready, and on the output when out_valid & out_ready.
REQ-020 Pipeline advance enable SHALL be en = ~out_valid | out_ready; in_ready = en & ~rst (combinational; no dependency on in_valid).
REQ-021 When en = 1, every stage SHALL shift one position; stage-0 valid SHALL load in_valid & in_ready; when en = 0, all stage registers and valid bits SHALL hold.
REQ-022 Latency SHALL be exactly STAGES cycles: operands accepted at edge t produce out_valid = 1 with the result after edge t+STAGES-1, i.e. visible in cycle t+STAGES, absent stalls.
REQ-023 Throughput SHALL be one operation per cycle with out_ready held high; bubbles (in_valid = 0) SHALL propagate as valid = 0 slots without disturbing neighbouring results.
REQ-024 s, cout and ovf SHALL remain stable while out_valid = 1 and out_ready = 0.
REQ-025 Results SHALL leave in acceptance order; no operation is dropped or duplicated under any stall pattern.
REQ-026 Simultaneous input accept and output retire in one cycle SHALL both take effect.
REQ-027 Wrap-around: the sum SHALL be truncated to N bits, with overflow reported only via cout/ovf.
REQ-028 sub and cin SHALL be sampled with a and b at acceptance and travel with their operation.

Reset
REQ-029 With rst = 1 at a rising edge, all stage valid bits SHALL clear and out_valid, s, cout and ovf SHALL become 0.
REQ-030 While rst = 1, in_ready SHALL be 0 and no operand SHALL be accepted.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight operations; none SHALL appear after rst deasserts.
REQ-032 In the first cycle after rst deasserts, in_ready SHALL be 1.

Verification (N=32, STAGES=4)
REQ-033 The bench SHALL check: a=0xFFFFFFFF, b=1, cin=0, sub=0, out_ready=1 -> 4 cycles later s=0, cout=1, ovf=0.
REQ-034 The bench SHALL check: a=0x7FFFFFFF, b=1, sub=0 -> s=0x80000000, cout=0, ovf=1; then a=5, b=7, sub=1 -> s=0xFFFFFFFE, cout=0, ovf=0.
REQ-035 The bench SHALL check: back-to-back stream of 8 random ops with out_ready=1 -> 8 consecutive out_valid cycles, results match the golden model in order.
REQ-036 The bench SHALL check: out_ready=0 for 6 cycles while in_valid=1 -> in_ready drops once out_valid=1, s held stable, exactly 4 ops buffered; on release all emerge in order, none lost.
REQ-037 The bench SHALL check: rst pulsed 1 cycle with 3 ops in flight -> out_valid=0, s=0, and no stale result appears afterwards.
REQ-038 The bench SHALL check: exhaustive N=4, STAGES=2 sweep over all a, b, cin, sub -> every result matches the golden model.
